// File: rtl/zoran_nios_key_in.sv
// Avalon-MM pushbutton/switch input port: two-flop synchroniser, per-bit debounce,
// W1C edge capture and a maskable level interrupt.
module zoran_nios_key_in #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter int unsigned      CNT_W           = 16,
    parameter int unsigned      EDGE            = 1,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;

    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic             w_unused;

    // Only the low WIDTH bits of writedata are meaningful.
    assign w_unused = &{1'b0, writedata};

    assign w_wr = chipselect && !write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= RESET_VAL;
            r_s2 <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments let s2 take the old s1, forming a true two-flop chain.
            r_s1 <= in_port;
            r_s2 <= r_s1;
        end
    end

    // A bit is accepted once it has differed from the stable level for DEBOUNCE_CYCLES samples.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        w_accept = '0;
        w_edge   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_accept[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
        end
        case (EDGE)
            0:       w_edge = w_accept & r_s2;
            1:       w_edge = w_accept & ~r_s2;
            default: w_edge = w_accept;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= RESET_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_stable <= (r_stable & ~w_accept) | (r_s2 & w_accept);
            for (int i = 0; i < WIDTH; i++) begin
                if ((r_s2[i] == r_stable[i]) || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_clr = (w_wr && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

    // A new edge in the same cycle as a W1C clear keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= '0;
            r_edgecap <= '0;
        end else begin
            if (w_wr && (address == 2'd2)) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = r_stable;
            2'd2:    readdata[WIDTH-1:0] = r_irqmask;
            2'd3:    readdata[WIDTH-1:0] = r_edgecap;
            default: readdata = '0;
        endcase
    end

    assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_zoran_nios_key_in.sv
// Scoreboard bench for zoran_nios_key_in: a history-window debounce model predicts
// readdata/irq each cycle; a negedge monitor pops and compares.
module tb_zoran_nios_key_in;

    localparam int          WIDTH = 4;
    localparam int          DB    = 4;
    localparam int          EDGE  = 1;
    localparam logic [3:0]  RST_V = 4'hF;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    zoran_nios_key_in #(
        .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB), .CNT_W(16), .EDGE(EDGE), .RESET_VAL(RST_V)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] rdata;
        logic        irq;
        int          ph;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: raw samples per edge; a level is accepted when the last DB
    // synchronised samples (raw samples delayed by two edges) all agree and differ.
    logic [3:0] m_hist[$];
    logic [3:0] m_stable;
    logic [3:0] m_mask;
    logic [3:0] m_edgecap;

    task automatic model_reset();
        m_hist.delete();
        for (int k = 0; k < DB + 2; k++) m_hist.push_back(RST_V);
        m_stable  = RST_V;
        m_mask    = 4'h0;
        m_edgecap = 4'h0;
    endtask

    task automatic model_edge();
        logic [3:0] ev;
        logic       v;
        logic       held;
        int         sz;
        if (!reset_n) return;
        ev = 4'h0;
        sz = m_hist.size();
        for (int b = 0; b < WIDTH; b++) begin
            v    = m_hist[sz-2][b];
            held = 1'b1;
            for (int j = sz - 1 - DB; j <= sz - 2; j++) begin
                if (m_hist[j][b] != v) held = 1'b0;
            end
            if (held && (v != m_stable[b])) begin
                m_stable[b] = v;
                if (EDGE == 2 || (EDGE == 1 && !v) || (EDGE == 0 && v)) ev[b] = 1'b1;
            end
        end
        if (chipselect && !write_n) begin
            if (address == 2'd2) m_mask = writedata[3:0];
            if (address == 2'd3) m_edgecap = m_edgecap & ~writedata[3:0];
        end
        m_edgecap = m_edgecap | ev;
        m_hist.push_back(in_port);
        if (m_hist.size() > DB + 2) void'(m_hist.pop_front());
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {28'h0, m_stable};
            2'd2:    return {28'h0, m_mask};
            2'd3:    return {28'h0, m_edgecap};
            default: return 32'h0;
        endcase
    endfunction

    // One clock: update model at the edge, drive new inputs, queue the expectation.
    task automatic step(input logic rn, input logic [3:0] inp, input logic [1:0] addr,
                        input logic cs, input logic wn, input logic [31:0] wd, input int ph);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        reset_n    = rn;
        in_port    = inp;
        address    = addr;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        if (!rn) model_reset();
        e.addr  = addr;
        e.rdata = model_rd(addr);
        e.irq   = |(m_edgecap & m_mask);
        e.ph    = ph;
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input logic [3:0] inp, input logic [1:0] addr, input int ph);
        for (int k = 0; k < n; k++) step(1'b1, inp, addr, 1'b0, 1'b1, 32'h0, ph);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                n_checks++;
                if (readdata !== mon_e.rdata) begin
                    n_fail++;
                    $display("FAIL phase%0d readdata@addr%0d: got %h expected %h at %0t",
                             mon_e.ph, mon_e.addr, readdata, mon_e.rdata, $time);
                end
                n_checks++;
                if (irq !== mon_e.irq) begin
                    n_fail++;
                    $display("FAIL phase%0d irq: got %b expected %b at %0t",
                             mon_e.ph, irq, mon_e.irq, $time);
                end
            end
        end
    end

    logic [3:0] cur_in;
    int         drain;

    initial begin
        reset_n    = 1'b0;
        in_port    = RST_V;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        model_reset();

        // Phase 1: reset state on every address, then release.
        step(1'b0, 4'hF, 2'd0, 1'b0, 1'b1, 32'h0, 1);
        step(1'b0, 4'hF, 2'd1, 1'b0, 1'b1, 32'h0, 1);
        step(1'b0, 4'hF, 2'd2, 1'b0, 1'b1, 32'h0, 1);
        step(1'b0, 4'hF, 2'd3, 1'b0, 1'b1, 32'h0, 1);
        idle(3, 4'hF, 2'd0, 1);

        // Phase 2: bit 0 falls and is held; DATA watched every cycle, then EDGECAP.
        idle(9, 4'hE, 2'd0, 2);
        idle(2, 4'hE, 2'd3, 2);

        // Phase 3: unmask bit 0, then W1C it; writes with chipselect low must be ignored.
        step(1'b1, 4'hE, 2'd2, 1'b0, 1'b0, 32'h1, 3);
        step(1'b1, 4'hE, 2'd2, 1'b1, 1'b0, 32'h1, 3);
        idle(2, 4'hE, 2'd2, 3);
        step(1'b1, 4'hE, 2'd3, 1'b1, 1'b0, 32'h1, 3);
        idle(2, 4'hE, 2'd3, 3);
        step(1'b1, 4'hE, 2'd2, 1'b1, 1'b0, 32'hF, 3);
        step(1'b1, 4'hE, 2'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 3);
        step(1'b1, 4'hE, 2'd0, 1'b1, 1'b0, 32'h0, 3);

        // Phase 4: bit 1 bounces (3 low, 1 high) then stays low.
        idle(3, 4'hC, 2'd0, 4);
        idle(1, 4'hE, 2'd0, 4);
        idle(8, 4'hC, 2'd0, 4);
        idle(2, 4'hC, 2'd3, 4);
        step(1'b1, 4'hC, 2'd3, 1'b1, 1'b0, 32'hF, 4);

        // Phase 5: bit 2 falls (captured), cleared, then rises (not captured).
        idle(8, 4'h8, 2'd0, 5);
        step(1'b1, 4'h8, 2'd3, 1'b1, 1'b0, 32'hF, 5);
        idle(8, 4'hC, 2'd0, 5);
        idle(2, 4'hC, 2'd3, 5);

        // Phase 6: continuous W1C on bit 3 while its fall is accepted; set must win.
        for (int k = 0; k < 9; k++) step(1'b1, 4'h4, 2'd3, 1'b1, 1'b0, 32'h8, 6);
        idle(2, 4'h4, 2'd3, 6);

        // Phase 7: reset mid-count, then first acceptance after release.
        idle(3, 4'h0, 2'd0, 7);
        step(1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 32'h0, 7);
        step(1'b0, 4'h0, 2'd3, 1'b0, 1'b1, 32'h0, 7);
        idle(8, 4'h0, 2'd0, 7);
        idle(2, 4'h0, 2'd3, 7);

        // Phase 8: randomized traffic with glitches, writes and rare resets.
        cur_in = 4'h0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 5) == 0) cur_in = cur_in ^ 4'($urandom_range(1, 15));
            step(($urandom_range(0, 199) != 0), cur_in, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom, 8);
        end

        drain = 0;
        while (sb.size() > 0 && drain < 5) begin
            @(posedge clk);
            drain++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
